// File: rtl/im_loader.sv
// im_loader: boot loader that assembles a framed, checksummed byte stream into
// big-endian instruction words and holds the CPU until the image is verified.
module im_loader #(
    parameter int NMEM = 20,
    parameter int AW   = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          restart,
    output logic          im_we,
    output logic [AW-1:0] im_waddr,
    output logic [31:0]   im_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);
    typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d, wcnt_q, wcnt_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [23:0]   word_q, word_d;
    logic [7:0]    xor_q, xor_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          acc;

    assign in_ready = (state_q != S_DONE) && (state_q != S_ERR);
    assign acc      = in_valid && in_ready;
    assign im_we    = we_q;
    assign im_waddr = waddr_q;
    assign im_wdata = wdata_q;
    assign cpu_hold = state_q != S_DONE;
    assign done     = state_q == S_DONE;
    assign err      = state_q == S_ERR;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        xor_d   = xor_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        // The checksum byte itself is excluded from the running XOR
        if (acc && state_q != S_CSUM) xor_d = xor_q ^ in_data;
        case (state_q)
            S_LEN_HI: if (acc) begin
                len_d[15:8] = in_data;
                state_d     = S_LEN_LO;
            end
            S_LEN_LO: if (acc) begin
                len_d[7:0] = in_data;
                state_d    = (len_d > 16'(NMEM)) ? S_ERR : (len_d == 16'd0) ? S_CSUM : S_DATA;
            end
            S_DATA: if (acc) begin
                word_d = {word_q[15:0], in_data};
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    we_d    = 1'b1;
                    wdata_d = {word_q, in_data};
                    waddr_d = wcnt_q[AW-1:0];
                    wcnt_d  = wcnt_q + 16'd1;
                    if (wcnt_d == len_q) state_d = S_CSUM;
                end
            end
            S_CSUM: if (acc) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
            default: if (restart) begin
                state_d = S_LEN_HI;
                len_d   = '0;
                wcnt_d  = '0;
                bcnt_d  = '0;
                xor_d   = '0;
                waddr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LEN_HI;
            len_q   <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            xor_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            xor_q   <= xor_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed frame vectors with hand-computed per-cycle outputs
// for im_loader, plus an asynchronous mid-payload reset sequence.
module tb_im_loader;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, restart = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, im_we, cpu_hold, done, err;
    logic [6:0]  im_waddr;
    logic [31:0] im_wdata;

    localparam logic [31:0] W1 = 32'h20080005, WA = 32'h8C010000, WB = 32'h00221820;

    always #5 clk = ~clk;

    im_loader #(.NMEM(20), .AW(7)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .restart(restart), .im_we(im_we), .im_waddr(im_waddr),
        .im_wdata(im_wdata), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    // expected = {in_ready, im_we, im_waddr, im_wdata, cpu_hold, done, err}
    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rs;
        logic [43:0] exp;
    } vec_t;

    vec_t q[$];
    int   n_cmp = 0, n_bad = 0;

    function automatic logic [43:0] obs();
        return {in_ready, im_we, im_waddr, im_wdata, cpu_hold, done, err};
    endfunction

    task automatic add(input logic v, input logic [7:0] d, input logic rs,
                       input logic rdy, input logic we, input logic [6:0] wa,
                       input logic [31:0] wd, input logic h, input logic dn, input logic er);
        q.push_back('{v, d, rs, {rdy, we, wa, wd, h, dn, er}});
    endtask

    task automatic chk(input string nm, input logic [43:0] exp);
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL %s: got rdy/we/addr/data/hold/done/err=%h expected %h", nm, obs(), exp);
        end
    endtask

    task automatic run(input string nm);
        foreach (q[i]) begin
            in_valid = q[i].v;
            in_data  = q[i].d;
            restart  = q[i].rs;
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d]", nm, i), q[i].exp);
        end
        q.delete();
        in_valid = 1'b0;
        restart  = 1'b0;
    endtask

    task automatic frame1();
        add(1, 8'h00, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 8'h01, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 8'h20, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 8'h08, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 8'h05, 0, 1, 1, 0, W1, 1, 0, 0);
        add(1, 8'h2C, 0, 0, 0, 0, W1, 0, 1, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("reset", {1'b1, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 1'b0});
        rst_n = 1'b1;

        frame1();
        add(0, 8'h00, 1, 1, 0, 0, W1, 1, 0, 0);
        run("single_word");

        add(1, 8'h00, 0, 1, 0, 0, W1, 1, 0, 0); add(0, 8'hFF, 0, 1, 0, 0, W1, 1, 0, 0);
        add(1, 8'h02, 0, 1, 0, 0, W1, 1, 0, 0); add(0, 8'hFF, 0, 1, 0, 0, W1, 1, 0, 0);
        add(1, 8'h8C, 0, 1, 0, 0, W1, 1, 0, 0); add(0, 8'hFF, 1, 1, 0, 0, W1, 1, 0, 0);
        add(1, 8'h01, 0, 1, 0, 0, W1, 1, 0, 0); add(0, 8'hFF, 0, 1, 0, 0, W1, 1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 0, W1, 1, 0, 0); add(0, 8'hFF, 0, 1, 0, 0, W1, 1, 0, 0);
        add(1, 8'h00, 0, 1, 1, 0, WA, 1, 0, 0); add(0, 8'hFF, 0, 1, 0, 0, WA, 1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 0, WA, 1, 0, 0); add(0, 8'hFF, 0, 1, 0, 0, WA, 1, 0, 0);
        add(1, 8'h22, 0, 1, 0, 0, WA, 1, 0, 0); add(0, 8'hFF, 0, 1, 0, 0, WA, 1, 0, 0);
        add(1, 8'h18, 0, 1, 0, 0, WA, 1, 0, 0); add(0, 8'hFF, 0, 1, 0, 0, WA, 1, 0, 0);
        add(1, 8'h20, 0, 1, 1, 1, WB, 1, 0, 0); add(0, 8'hFF, 0, 1, 0, 1, WB, 1, 0, 0);
        add(1, 8'h95, 0, 0, 0, 1, WB, 0, 1, 0); add(0, 8'hFF, 0, 0, 0, 1, WB, 0, 1, 0);
        add(0, 8'h00, 1, 1, 0, 0, WB, 1, 0, 0);
        run("two_word_gapped");

        add(1, 8'h00, 0, 1, 0, 0, WB, 1, 0, 0);
        add(1, 8'h01, 0, 1, 0, 0, WB, 1, 0, 0);
        add(1, 8'h20, 0, 1, 0, 0, WB, 1, 0, 0);
        add(1, 8'h08, 0, 1, 0, 0, WB, 1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 0, WB, 1, 0, 0);
        add(1, 8'h05, 0, 1, 1, 0, W1, 1, 0, 0);
        add(1, 8'h2D, 0, 0, 0, 0, W1, 1, 0, 1);
        add(1, 8'hAA, 0, 0, 0, 0, W1, 1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 0, W1, 1, 0, 0);
        run("bad_csum");

        add(1, 8'h00, 0, 1, 0, 0, W1, 1, 0, 0);
        add(1, 8'h15, 0, 0, 0, 0, W1, 1, 0, 1);
        add(1, 8'h00, 0, 0, 0, 0, W1, 1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 0, W1, 1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 0, W1, 1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 0, W1, 1, 0, 0);
        add(1, 8'h00, 0, 0, 0, 0, W1, 0, 1, 0);
        add(0, 8'h00, 1, 1, 0, 0, W1, 1, 0, 0);
        run("len_too_big_then_empty");

        add(1, 8'h00, 0, 1, 0, 0, W1, 1, 0, 0);
        add(1, 8'h14, 0, 1, 0, 0, W1, 1, 0, 0);
        add(1, 8'h8C, 0, 1, 0, 0, W1, 1, 0, 0);
        add(1, 8'h01, 0, 1, 0, 0, W1, 1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 0, W1, 1, 0, 0);
        add(1, 8'h00, 0, 1, 1, 0, WA, 1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 0, WA, 1, 0, 0);
        add(1, 8'h22, 0, 1, 0, 0, WA, 1, 0, 0);
        run("len_max_partial");

        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {1'b1, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame1();
        run("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
